// File: rtl/miner_core_nonce_ctrl.sv
// miner_core_nonce_ctrl
//   Upstream sequencer for the miner core. Walks an inclusive nonce range, launches one
//   double-SHA-256 run per nonce on the CCU, compares each final digest against the
//   difficulty target and reports the first winning nonce, range exhaustion or a hung core.
//
// Ports
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_start, i_abort   launch a search (IDLE/DONE only) / cancel from any state
//   i_nonce_base       first nonce, latched on accepted start
//   i_nonce_limit      last nonce (inclusive), latched on accepted start
//   i_target           difficulty target, latched on accepted start
//   i_finished         CCU done strobe, i_digest valid alongside it
//   o_hash_enable      one-cycle launch pulse to the CCU
//   o_nonce            nonce under test, stable from ISSUE through CHECK
//   o_busy             high in ISSUE/WAIT/CHECK
//   o_found, o_exhausted, o_timeout   DONE status levels
//   o_golden_nonce     winning nonce when o_found=1
//   o_hash_count       completed runs in the current search (wraps)
module miner_core_nonce_ctrl #(
    parameter int unsigned NONCE_W  = 32,
    parameter int unsigned DIGEST_W = 256,
    parameter int unsigned TIMEOUT  = 511
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [NONCE_W-1:0]  i_nonce_base,
    input  logic [NONCE_W-1:0]  i_nonce_limit,
    input  logic [DIGEST_W-1:0] i_target,
    input  logic                i_finished,
    input  logic [DIGEST_W-1:0] i_digest,
    output logic                o_hash_enable,
    output logic [NONCE_W-1:0]  o_nonce,
    output logic                o_busy,
    output logic                o_found,
    output logic                o_exhausted,
    output logic                o_timeout,
    output logic [NONCE_W-1:0]  o_golden_nonce,
    output logic [NONCE_W-1:0]  o_hash_count
);

    localparam int unsigned WD_W = 10;
    localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]    WD_ONE   = WD_W'(1);
    localparam logic [NONCE_W-1:0] N_ONE    = NONCE_W'(1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e               r_state,       w_state_next;
    logic [NONCE_W-1:0]   r_nonce,       w_nonce_next;
    logic [NONCE_W-1:0]   r_limit,       w_limit_next;
    logic [DIGEST_W-1:0]  r_target,      w_target_next;
    logic [DIGEST_W-1:0]  r_digest,      w_digest_next;
    logic [WD_W-1:0]      r_wdog,        w_wdog_next;
    logic                 r_found,       w_found_next;
    logic                 r_exhausted,   w_exhausted_next;
    logic                 r_timeout,     w_timeout_next;
    logic [NONCE_W-1:0]   r_golden,      w_golden_next;
    logic [NONCE_W-1:0]   r_hash_count,  w_hash_count_next;
    logic                 w_hash_enable;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_nonce      <= '0;
            r_limit      <= '0;
            r_target     <= '0;
            r_digest     <= '0;
            r_wdog       <= '0;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
            r_timeout    <= 1'b0;
            r_golden     <= '0;
            r_hash_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_nonce      <= w_nonce_next;
            r_limit      <= w_limit_next;
            r_target     <= w_target_next;
            r_digest     <= w_digest_next;
            r_wdog       <= w_wdog_next;
            r_found      <= w_found_next;
            r_exhausted  <= w_exhausted_next;
            r_timeout    <= w_timeout_next;
            r_golden     <= w_golden_next;
            r_hash_count <= w_hash_count_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_nonce_next      = r_nonce;
        w_limit_next      = r_limit;
        w_target_next     = r_target;
        w_digest_next     = r_digest;
        w_wdog_next       = r_wdog;
        w_found_next      = r_found;
        w_exhausted_next  = r_exhausted;
        w_timeout_next    = r_timeout;
        w_golden_next     = r_golden;
        w_hash_count_next = r_hash_count;
        w_hash_enable     = 1'b0;

        if (i_abort) begin
            // Abort outranks everything, including a simultaneous start.
            w_state_next      = StIdle;
            w_found_next      = 1'b0;
            w_exhausted_next  = 1'b0;
            w_timeout_next    = 1'b0;
            w_golden_next     = '0;
            w_hash_count_next = '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        w_nonce_next      = i_nonce_base;
                        w_limit_next      = i_nonce_limit;
                        w_target_next     = i_target;
                        w_found_next      = 1'b0;
                        w_exhausted_next  = 1'b0;
                        w_timeout_next    = 1'b0;
                        w_golden_next     = '0;
                        w_hash_count_next = '0;
                        w_state_next      = StIssue;
                    end
                end
                StIssue: begin
                    w_hash_enable = 1'b1;
                    w_wdog_next   = '0;
                    w_state_next  = StWait;
                end
                StWait: begin
                    // A finish on the same edge as watchdog expiry still counts.
                    if (i_finished) begin
                        w_digest_next     = i_digest;
                        w_hash_count_next = r_hash_count + N_ONE;
                        w_state_next      = StCheck;
                    end else if (r_wdog == WD_LIMIT) begin
                        w_timeout_next = 1'b1;
                        w_state_next   = StDone;
                    end else begin
                        w_wdog_next = r_wdog + WD_ONE;
                    end
                end
                StCheck: begin
                    if (r_digest < r_target) begin
                        w_golden_next = r_nonce;
                        w_found_next  = 1'b1;
                        w_state_next  = StDone;
                    end else if (r_nonce == r_limit) begin
                        w_exhausted_next = 1'b1;
                        w_state_next     = StDone;
                    end else begin
                        // Wraps through all-ones to zero when limit < base.
                        w_nonce_next = r_nonce + N_ONE;
                        w_state_next = StIssue;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    assign o_hash_enable  = w_hash_enable;
    assign o_nonce        = r_nonce;
    assign o_busy         = (r_state == StIssue) || (r_state == StWait) || (r_state == StCheck);
    assign o_found        = r_found;
    assign o_exhausted    = r_exhausted;
    assign o_timeout      = r_timeout;
    assign o_golden_nonce = r_golden;
    assign o_hash_count   = r_hash_count;

endmodule

// File: tb/tb_miner_core_nonce_ctrl.sv
module tb_miner_core_nonce_ctrl;

    localparam int unsigned NONCE_W  = 32;
    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned TIMEOUT  = 511;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic [NONCE_W-1:0]  nonce_base;
    logic [NONCE_W-1:0]  nonce_limit;
    logic [DIGEST_W-1:0] target;
    logic                finished;
    logic [DIGEST_W-1:0] digest;
    logic                hash_enable;
    logic [NONCE_W-1:0]  nonce;
    logic                busy;
    logic                found;
    logic                exhausted;
    logic                timeout;
    logic [NONCE_W-1:0]  golden_nonce;
    logic [NONCE_W-1:0]  hash_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // CCU model controls
    bit ccu_on  = 1'b1;
    int ccu_lat = 3;
    int ccu_mode = 0;
    int ccu_cnt = 0;
    logic [NONCE_W-1:0] ccu_nonce = '0;

    // Scoreboard: nonces expected on successive hash_enable pulses
    logic [NONCE_W-1:0] exp_q[$];

    miner_core_nonce_ctrl #(
        .NONCE_W (NONCE_W),
        .DIGEST_W(DIGEST_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_nonce_base  (nonce_base),
        .i_nonce_limit (nonce_limit),
        .i_target      (target),
        .i_finished    (finished),
        .i_digest      (digest),
        .o_hash_enable (hash_enable),
        .o_nonce       (nonce),
        .o_busy        (busy),
        .o_found       (found),
        .o_exhausted   (exhausted),
        .o_timeout     (timeout),
        .o_golden_nonce(golden_nonce),
        .o_hash_count  (hash_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DIGEST_W-1:0] digest_for(input logic [NONCE_W-1:0] n);
        case (ccu_mode)
            0:       return '0;
            1:       return target;
            default: return (n == '0) ? '0 : {DIGEST_W{1'b1}};
        endcase
    endfunction

    // CCU model: a new launch always restarts the countdown.
    always @(posedge clk) begin
        finished <= 1'b0;
        if (hash_enable && ccu_on) begin
            ccu_cnt   <= ccu_lat;
            ccu_nonce <= nonce;
        end else if (ccu_cnt != 0) begin
            ccu_cnt <= ccu_cnt - 1;
            if (ccu_cnt == 1) begin
                finished <= 1'b1;
                digest   <= digest_for(ccu_nonce);
            end
        end
    end

    // Pulse monitor pops the scoreboard.
    always @(negedge clk) begin
        if (hash_enable) begin
            pulses++;
            if (exp_q.size() == 0) chk("unexpected_pulse", 64'(nonce), 64'hDEAD);
            else                   chk("pulse_nonce", 64'(nonce), 64'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [NONCE_W-1:0] b, input logic [NONCE_W-1:0] l,
                            input logic [DIGEST_W-1:0] t);
        nonce_base  = b;
        nonce_limit = l;
        target      = t;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (found || exhausted || timeout) done = 1'b1;
        end
        if (!done) chk({tag, "_done_bound"}, 64'(0), 64'(1));
    endtask

    initial begin
        int p0;
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        nonce_base = '0; nonce_limit = '0; target = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_hash_enable", 64'(hash_enable), 64'(0));
        chk("rst_status", 64'({found, exhausted, timeout}), 64'(0));
        chk("rst_nonce", 64'(nonce), 64'(0));
        chk("rst_hash_count", 64'(hash_count), 64'(0));
        @(posedge clk); #1; rst = 1'b0;

        // 1: first nonce wins, slow CCU
        ccu_mode = 0; ccu_lat = 337; p0 = pulses;
        exp_q.push_back(32'd5);
        do_start(32'd5, 32'd8, {DIGEST_W{1'b1}});
        chk("t1_issue_latency", 64'(hash_enable), 64'(1));
        chk("t1_busy", 64'(busy), 64'(1));
        wait_done("t1");
        chk("t1_found", 64'(found), 64'(1));
        chk("t1_golden", 64'(golden_nonce), 64'(5));
        chk("t1_hash_count", 64'(hash_count), 64'(1));
        chk("t1_pulses", 64'(pulses - p0), 64'(1));
        chk("t1_exhausted", 64'(exhausted), 64'(0));

        // 2: equal digest never wins -> exhausted
        ccu_mode = 1; ccu_lat = 3; p0 = pulses;
        for (int i = 0; i < 4; i++) exp_q.push_back(NONCE_W'(i));
        do_start(32'd0, 32'd3, 256'd1);
        chk("t2_status_cleared", 64'(found), 64'(0));
        wait_done("t2");
        chk("t2_exhausted", 64'(exhausted), 64'(1));
        chk("t2_found", 64'(found), 64'(0));
        chk("t2_hash_count", 64'(hash_count), 64'(4));
        chk("t2_pulses", 64'(pulses - p0), 64'(4));

        // 3: wrapping range, win on nonce 0
        ccu_mode = 2; p0 = pulses;
        exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
        do_start(32'hFFFF_FFFE, 32'd1, 256'd100);
        wait_done("t3");
        chk("t3_found", 64'(found), 64'(1));
        chk("t3_golden", 64'(golden_nonce), 64'(0));
        chk("t3_hash_count", 64'(hash_count), 64'(3));

        // 4: hung CCU -> timeout TIMEOUT+1 cycles after WAIT entry
        ccu_on = 1'b0;
        exp_q.push_back(32'd7);
        do_start(32'd7, 32'd9, {DIGEST_W{1'b1}});
        n = 0;
        while (!timeout && n < 600) begin step(); n++; end
        chk("t4_timeout_cycles", 64'(n), 64'(TIMEOUT + 2));
        chk("t4_timeout", 64'(timeout), 64'(1));
        chk("t4_found", 64'(found), 64'(0));
        chk("t4_busy", 64'(busy), 64'(0));
        ccu_on = 1'b1;

        // 5: abort mid-WAIT, late finish, start+abort together
        ccu_mode = 0; ccu_lat = 20;
        exp_q.push_back(32'd10);
        do_start(32'd10, 32'd20, {DIGEST_W{1'b1}});
        repeat (4) step();
        abort = 1'b1; step(); abort = 1'b0;
        chk("t5_abort_idle", 64'(busy), 64'(0));
        chk("t5_abort_clear", 64'({found, exhausted, timeout}), 64'(0));
        p0 = pulses;
        repeat (30) step();
        chk("t5_late_finish_ignored", 64'(busy), 64'(0));
        chk("t5_no_pulse", 64'(pulses - p0), 64'(0));
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        chk("t5_abort_beats_start", 64'(busy), 64'(0));
        chk("t5_no_enable", 64'(hash_enable), 64'(0));
        exp_q.push_back(32'd40);
        do_start(32'd40, 32'd40, {DIGEST_W{1'b1}});
        chk("t5_count_zero", 64'(hash_count), 64'(0));
        wait_done("t5");
        chk("t5_golden", 64'(golden_nonce), 64'(40));
        chk("t5_hash_count", 64'(hash_count), 64'(1));

        // 6: asynchronous reset mid-WAIT
        exp_q.push_back(32'd3);
        do_start(32'd3, 32'd9, {DIGEST_W{1'b1}});
        repeat (5) step();
        @(negedge clk); #2; rst = 1'b1; #1;
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_nonce", 64'(nonce), 64'(0));
        chk("t6_rst_status", 64'({found, exhausted, timeout, hash_enable}), 64'(0));
        chk("t6_rst_golden", 64'(golden_nonce), 64'(0));
        @(posedge clk); #1; rst = 1'b0;
        exp_q.push_back(32'd3);
        do_start(32'd3, 32'd3, {DIGEST_W{1'b1}});
        chk("t6_restart", 64'(hash_enable), 64'(1));
        wait_done("t6");
        chk("t6_found", 64'(found), 64'(1));
        chk("t6_golden", 64'(golden_nonce), 64'(3));

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
